// File: rtl/rv32_bus_arbiter.sv
// Merges the rv32 instruction and data buses onto one shared memory bus.
// Alternating arbitration, owner held until the slave answers, with a timeout watchdog.
module rv32_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES     = 16,
  parameter logic [31:0] TIMEOUT_READ_VALUE = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in,
  output logic        timeout_out
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic          locked, locked_nx;
  logic          owner_q, owner_nx;
  logic          last_q, last_nx;
  logic [CW-1:0] wait_cnt, wait_nx;
  logic          instr_req, data_req, active, owner, to_hit, done;
  logic [31:0]   rvalue;

  // owner: 0 = instr, 1 = data
  always_comb begin
    instr_req = instr_read_in;
    data_req  = data_read_in | data_write_in;
    active    = !reset && (locked || instr_req || data_req);
    if (locked)                     owner = owner_q;
    else if (instr_req && data_req) owner = ~last_q;
    else                            owner = data_req;
    to_hit = TO_EN && locked && (wait_cnt == TO_LIMIT) && !mem_ready_in;
    done   = active && (mem_ready_in || to_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wait_cnt <= '0;
    end else begin
      locked   <= locked_nx;
      owner_q  <= owner_nx;
      last_q   <= last_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    locked_nx = locked;
    owner_nx  = owner_q;
    last_nx   = last_q;
    wait_nx   = wait_cnt;
    if (done) begin
      locked_nx = 1'b0;
      last_nx   = owner;
      wait_nx   = '0;
    end else if (active && !locked) begin
      locked_nx = 1'b1;
      owner_nx  = owner;
      wait_nx   = CW'(1);
    end else if (locked && TO_EN) begin
      wait_nx = wait_cnt + CW'(1);
    end
  end

  always_comb begin
    mem_address_out      = '0;
    mem_read_out         = 1'b0;
    mem_write_out        = 1'b0;
    mem_write_mask_out   = '0;
    mem_write_value_out  = '0;
    instr_ready_out      = 1'b0;
    instr_read_value_out = '0;
    data_ready_out       = 1'b0;
    data_read_value_out  = '0;
    timeout_out          = active && to_hit;
    rvalue               = to_hit ? TIMEOUT_READ_VALUE : mem_read_value_in;
    if (active) begin
      if (owner) begin
        mem_address_out     = data_address_in;
        mem_read_out        = data_read_in;
        mem_write_out       = data_write_in;
        mem_write_mask_out  = data_write_mask_in;
        mem_write_value_out = data_write_value_in;
      end else begin
        mem_address_out = instr_address_in;
        mem_read_out    = instr_read_in;
      end
      // a forced termination must not leave a strobe on the bus
      if (to_hit) begin
        mem_read_out  = 1'b0;
        mem_write_out = 1'b0;
      end
    end
    if (done) begin
      if (owner) begin
        data_ready_out      = 1'b1;
        data_read_value_out = rvalue;
      end else begin
        instr_ready_out      = 1'b1;
        instr_read_value_out = rvalue;
      end
    end
  end
endmodule
